// File: rtl/fifo_pkg.sv
// Shared parameters and types for the threshold FIFO bank.
// Occupancy state is derived from count, never registered.
package fifo_pkg;
    localparam int DATA_W   = 6;
    localparam int ADDR_W   = 3;
    localparam int BAJO_RST = 1;
    localparam int ALTO_RST = 6;
    localparam int DEPTH    = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_PARTIAL,
        ST_FULL
    } fifo_st_e;
endpackage

// File: rtl/memoria_dual.sv
// Storage array: synchronous write, registered read.
// Only the read register is reset; contents persist.
module memoria_dual
    import fifo_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = ADDR_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    // Write port: store the word at waddr
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read port: capture old contents, hold when idle
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/fifo_umbrales.sv
// Single-clock FIFO with programmable low/high
// occupancy thresholds and a sticky error flag.
module fifo_umbrales
    import fifo_pkg::*;
#(
    parameter int DATA_W   = fifo_pkg::DATA_W,
    parameter int ADDR_W   = fifo_pkg::ADDR_W,
    parameter int BAJO_RST = fifo_pkg::BAJO_RST,
    parameter int ALTO_RST = fifo_pkg::ALTO_RST
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              thr_load,
    input  logic [ADDR_W-1:0] umbral_bajo,
    input  logic [ADDR_W-1:0] umbral_alto,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_en,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic              error
);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(2 ** ADDR_W);
    localparam logic [ADDR_W:0] ONE_CNT  = (ADDR_W + 1)'(1);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W-1:0] bajo_q, bajo_d;
    logic [ADDR_W-1:0] alto_q, alto_d;
    logic              valid_q, valid_d;
    logic              error_q, error_d;
    logic              wr_acc, rd_acc;
    fifo_st_e          st;

    // Occupancy state decoded from the registered count
    always_comb begin
        st = ST_PARTIAL;
        if (count_q == '0) begin
            st = ST_EMPTY;
        end else if (count_q == FULL_CNT) begin
            st = ST_FULL;
        end
    end

    // Accept decisions and next-state for pointers, count, flags
    always_comb begin
        rd_acc   = rd_en && (st != ST_EMPTY);
        wr_acc   = wr_en && ((st != ST_FULL) || rd_acc);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        bajo_d   = bajo_q;
        alto_d   = alto_q;
        valid_d  = rd_acc;
        error_d  = error_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (wr_acc && !rd_acc) begin
            count_d = count_q + ONE_CNT;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - ONE_CNT;
        end
        if (thr_load) begin
            bajo_d = umbral_bajo;
            alto_d = umbral_alto;
        end
        if ((wr_en && (st == ST_FULL) && !rd_en) ||
            (rd_en && (st == ST_EMPTY))) begin
            error_d = 1'b1;
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            bajo_q   <= ADDR_W'(BAJO_RST);
            alto_q   <= ADDR_W'(ALTO_RST);
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            bajo_q   <= bajo_d;
            alto_q   <= alto_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
        end
    end

    memoria_dual #(
        .DW(DATA_W),
        .AW(ADDR_W)
    ) u_mem (
        .clk  (clk),
        .reset(reset),
        .we   (wr_acc),
        .waddr(wr_ptr_q),
        .wdata(data_in),
        .re   (rd_acc),
        .raddr(rd_ptr_q),
        .rdata(data_out)
    );

    assign valid_out    = valid_q;
    assign count        = count_q;
    assign empty        = (st == ST_EMPTY);
    assign full         = (st == ST_FULL);
    assign almost_empty = (count_q <= {1'b0, bajo_q});
    assign almost_full  = (count_q >= {1'b0, alto_q});
    assign error        = error_q;
endmodule

// File: tb/tb_fifo_umbrales.sv
// Scoreboard bench for fifo_umbrales.
// Queue model predicts occupancy, flags and read data.
module tb_fifo_umbrales;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       thr_load = 1'b0;
    logic [2:0] umbral_bajo = '0;
    logic [2:0] umbral_alto = '0;
    logic       wr_en = 1'b0;
    logic [5:0] data_in = '0;
    logic       rd_en = 1'b0;
    logic [5:0] data_out;
    logic       valid_out;
    logic [3:0] count;
    logic       empty, full;
    logic       almost_empty, almost_full;
    logic       error;

    int n_tests = 0;
    int n_fail  = 0;

    logic [5:0] mq   [$];
    logic [5:0] expq [$];
    logic [5:0] mdout;
    logic       merr;
    int         mbajo, malto;

    always #5 clk = ~clk;

    fifo_umbrales dut (
        .clk         (clk),
        .reset       (reset),
        .thr_load    (thr_load),
        .umbral_bajo (umbral_bajo),
        .umbral_alto (umbral_alto),
        .wr_en       (wr_en),
        .data_in     (data_in),
        .rd_en       (rd_en),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .almost_empty(almost_empty),
        .almost_full (almost_full),
        .error       (error)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_state();
        int n;
        n = mq.size();
        chk("count", int'(count), n);
        chk("empty", int'(empty), int'(n == 0));
        chk("full", int'(full), int'(n == 8));
        chk("almost_empty", int'(almost_empty), int'(n <= mbajo));
        chk("almost_full", int'(almost_full), int'(n >= malto));
        chk("error", int'(error), int'(merr));
        chk("data_out", int'(data_out), int'(mdout));
    endtask

    task automatic cyc(input logic w, input logic [5:0] d,
                       input logic r, input logic t,
                       input logic [2:0] b, input logic [2:0] a);
        logic racc, wacc;
        logic [5:0] e;
        int n;
        wr_en = w;
        data_in = d;
        rd_en = r;
        thr_load = t;
        umbral_bajo = b;
        umbral_alto = a;
        n = mq.size();
        racc = r && (n != 0);
        wacc = w && ((n != 8) || racc);
        if ((r && n == 0) || (w && n == 8 && !r)) merr = 1'b1;
        if (racc) begin
            mdout = mq.pop_front();
            expq.push_back(mdout);
        end
        if (wacc) mq.push_back(d);
        if (t) begin
            mbajo = int'(b);
            malto = int'(a);
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        thr_load = 1'b0;
        chk("valid_out", int'(valid_out), int'(racc));
        if (valid_out) begin
            if (expq.size() == 0) begin
                chk("sb_underrun", 1, 0);
            end else begin
                e = expq.pop_front();
                chk("sb_data", int'(data_out), int'(e));
            end
        end
        chk_state();
    endtask

    task automatic wr(input logic [5:0] d);
        cyc(1'b1, d, 1'b0, 1'b0, 3'd0, 3'd0);
    endtask

    task automatic rd();
        cyc(1'b0, 6'd0, 1'b1, 1'b0, 3'd0, 3'd0);
    endtask

    task automatic do_reset(input int n, input logic w, input logic r);
        reset = 1'b1;
        wr_en = w;
        rd_en = r;
        data_in = 6'h3F;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        mq.delete();
        expq.delete();
        mdout = '0;
        merr = 1'b0;
        mbajo = 1;
        malto = 6;
        chk("rst_valid", int'(valid_out), 0);
        chk_state();
    endtask

    initial begin
        mdout = '0;
        merr = 1'b0;
        mbajo = 1;
        malto = 6;

        do_reset(2, 1'b0, 1'b0);

        for (int i = 1; i <= 8; i++) wr(6'(i));
        wr(6'h09);

        for (int i = 0; i < 8; i++) rd();
        rd();

        do_reset(1, 1'b0, 1'b0);
        cyc(1'b0, 6'd0, 1'b0, 1'b1, 3'd2, 3'd4);
        for (int i = 0; i < 4; i++) wr(6'h11 + 6'(i));
        rd();
        rd();

        do_reset(1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) wr(6'h18 + 6'(i));
        cyc(1'b1, 6'h2A, 1'b1, 1'b0, 3'd0, 3'd0);
        for (int i = 0; i < 8; i++) rd();

        do_reset(1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) wr(6'h10 + 6'(i));
        for (int i = 0; i < 6; i++) rd();
        for (int i = 0; i < 3; i++) wr(6'h20 + 6'(i));
        for (int i = 0; i < 6; i++) begin
            cyc(i < 3, 6'h30 + 6'(i), 1'b1, 1'b0, 3'd0, 3'd0);
        end
        wr(6'h05);
        wr(6'h06);
        do_reset(1, 1'b1, 1'b1);
        wr(6'h07);
        wr(6'h08);
        rd();

        for (int i = 0; i < 80; i++) begin
            cyc(1'($urandom_range(0, 1)), 6'($urandom),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 9) == 0),
                3'($urandom), 3'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
